// File: rtl/memu_pkg.sv
// Shared encodings and zip layouts for the MEM stage of the LoongArch pipeline.
// Field order mirrors what EXEU packs and WBU unpacks.
package memu_pkg;

  localparam int EXE2MEM_LEN = 172;
  localparam int MEM2WB_LEN  = 167;
  localparam int RF_ZIP_LEN  = 39;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
    logic [3:0]  mem_op;
    logic [31:0] pc;
    logic        csr_read;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ex_valid;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        is_ertn;
  } exe2mem_t;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic uns);
    return uns ? {24'h000000, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic uns);
    return uns ? {16'h0000, h} : {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/memu_load_align.sv
// Picks the addressed byte/halfword out of a 32-bit read word and extends it.
module memu_load_align
  import memu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr,
  input  logic [3:0]  mem_op,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = raw[{addr, 3'b000} +: 8];
  assign half_s = addr[1] ? raw[31:16] : raw[15:0];

  // size/extension select; store ops pass the word through untouched
  always_comb begin
    load_data = raw;
    if (mem_op[2]) begin
      load_data = raw;
    end else begin
      case (mem_op[1:0])
        SZ_B:    load_data = ext8(byte_s, mem_op[3]);
        SZ_H:    load_data = ext16(half_s, mem_op[3]);
        SZ_W:    load_data = raw;
        default: load_data = raw;
      endcase
    end
  end

endmodule

// File: rtl/memu.sv
// MEM stage: latches EXE's zip, aligns SRAM load data (held across WB stalls)
// and forwards the result to WB, IDU and EXEU.
module memu
  import memu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  output logic                   mem_allowin,
  input  logic                   exe_to_mem_valid,
  input  logic [EXE2MEM_LEN-1:0] exe_to_mem_zip,
  input  logic [31:0]            data_sram_rdata,
  input  logic                   wb_allowin,
  output logic                   mem_to_wb_valid,
  output logic [MEM2WB_LEN-1:0]  mem_to_wb_zip,
  output logic [RF_ZIP_LEN-1:0]  mem_rf_zip,
  output logic                   mem_ex
);

  exe2mem_t    zip_r;
  logic        mem_valid_r;
  logic        first_r;
  logic        rdata_held_r;
  logic [31:0] hold_buf_r;

  logic        load_s;
  logic [31:0] raw_s;
  logic [31:0] load_data_s;
  logic [31:0] final_s;

  assign mem_allowin = ~mem_valid_r | wb_allowin;
  assign load_s      = exe_to_mem_valid & mem_allowin;

  // pipeline register, first-cycle flag and stall hold buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid_r  <= 1'b0;
      first_r      <= 1'b0;
      rdata_held_r <= 1'b0;
      hold_buf_r   <= 32'h0000_0000;
      zip_r        <= '0;
    end else begin
      if (flush) begin
        mem_valid_r <= 1'b0;
      end else if (mem_allowin) begin
        mem_valid_r <= exe_to_mem_valid;
      end else begin
        mem_valid_r <= mem_valid_r;
      end

      if (load_s) begin
        zip_r <= exe2mem_t'(exe_to_mem_zip);
      end else begin
        zip_r <= zip_r;
      end

      first_r <= load_s;

      // SRAM data is only valid in the first cycle; keep it if WB is not taking it
      if (flush || wb_allowin) begin
        rdata_held_r <= 1'b0;
      end else if (first_r && mem_valid_r && !rdata_held_r) begin
        rdata_held_r <= 1'b1;
        hold_buf_r   <= data_sram_rdata;
      end else begin
        rdata_held_r <= rdata_held_r;
      end
    end
  end

  assign raw_s = rdata_held_r ? hold_buf_r : data_sram_rdata;

  memu_load_align u_load_align (
    .raw       (raw_s),
    .addr      (zip_r.result[1:0]),
    .mem_op    (zip_r.mem_op),
    .load_data (load_data_s)
  );

  // a faulting load never issued a request, so its ALU result goes through
  assign final_s = (zip_r.res_from_mem & ~zip_r.ex_valid) ? load_data_s : zip_r.result;

  assign mem_to_wb_valid = mem_valid_r;
  assign mem_to_wb_zip   = {zip_r.rf_we, zip_r.rf_waddr, final_s, zip_r.pc,
                            zip_r.csr_read, zip_r.csr_we, zip_r.csr_num,
                            zip_r.csr_wmask, zip_r.csr_wvalue,
                            zip_r.ex_valid, zip_r.ecode, zip_r.esubcode, zip_r.is_ertn};
  assign mem_rf_zip      = {mem_valid_r & zip_r.csr_read, mem_valid_r & zip_r.rf_we,
                            zip_r.rf_waddr, final_s};
  assign mem_ex          = mem_valid_r & (zip_r.ex_valid | zip_r.is_ertn);

endmodule

// File: tb/tb_memu.sv
// Scoreboard bench for memu: expected WB zips are queued at issue and checked
// by a monitor whenever WB accepts; handshake/status outputs are checked inline.
module tb_memu;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         mem_allowin;
  logic         exe_to_mem_valid;
  logic [171:0] exe_to_mem_zip;
  logic [31:0]  data_sram_rdata;
  logic         wb_allowin;
  logic         mem_to_wb_valid;
  logic [166:0] mem_to_wb_zip;
  logic [38:0]  mem_rf_zip;
  logic         mem_ex;

  int n_tests = 0;
  int n_fail  = 0;
  logic [166:0] exp_q[$];

  memu dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .mem_allowin      (mem_allowin),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_to_mem_zip   (exe_to_mem_zip),
    .data_sram_rdata  (data_sram_rdata),
    .wb_allowin       (wb_allowin),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_to_wb_zip    (mem_to_wb_zip),
    .mem_rf_zip       (mem_rf_zip),
    .mem_ex           (mem_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [166:0] act, input logic [166:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [171:0] mk_ex(input logic rfm, input logic we, input logic [4:0] wa,
      input logic [31:0] res, input logic [3:0] op, input logic [31:0] pc, input logic crd,
      input logic exv, input logic [5:0] ec, input logic [8:0] esc, input logic ertn);
    return {rfm, we, wa, res, op, pc, crd, 1'b1, 14'h0123, 32'hFFFF_0000,
            pc ^ 32'h0F0F_0F0F, exv, ec, esc, ertn};
  endfunction

  function automatic logic [166:0] mk_wb(input logic we, input logic [4:0] wa,
      input logic [31:0] fin, input logic [31:0] pc, input logic crd,
      input logic exv, input logic [5:0] ec, input logic [8:0] esc, input logic ertn);
    return {we, wa, fin, pc, crd, 1'b1, 14'h0123, 32'hFFFF_0000,
            pc ^ 32'h0F0F_0F0F, exv, ec, esc, ertn};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [171:0] z, input logic [31:0] rd);
    exe_to_mem_valid = 1'b1;
    exe_to_mem_zip   = z;
    cyc();
    exe_to_mem_valid = 1'b0;
    data_sram_rdata  = rd;
  endtask

  // monitor: every instruction WB accepts must match the next queued expectation
  always @(negedge clk) begin
    if (!reset && !flush && mem_to_wb_valid && wb_allowin) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", mem_to_wb_zip, 167'd0);
        if (mem_to_wb_zip == 167'd0) begin
          n_fail++;
          $display("FAIL wb_unexpected: got transfer expected none");
        end
      end else begin
        chk("wb_zip", mem_to_wb_zip, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; exe_to_mem_valid = 1'b0;
    exe_to_mem_zip = 172'd0; data_sram_rdata = 32'h0; wb_allowin = 1'b1;
    @(negedge clk);
    chk("rst_allowin", mem_allowin, 1'b1);
    chk("rst_valid",   mem_to_wb_valid, 1'b0);
    chk("rst_ex",      mem_ex, 1'b0);
    chk("rst_rfvalid", mem_rf_zip[38:37], 2'b00);
    chk("rst_zip",     mem_to_wb_zip, 167'd0);
    cyc();
    reset = 1'b0;
    cyc();

    // aligned/extended loads with WB always ready
    exp_q.push_back(mk_wb(1'b1, 5'd4, 32'hFFFF_FF80, 32'h1C00_0000, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0));
    issue(mk_ex(1'b1, 1'b1, 5'd4, 32'h1000_0003, 4'b0000, 32'h1C00_0000, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0), 32'h8012_3456);
    cyc();
    exp_q.push_back(mk_wb(1'b1, 5'd6, 32'h0000_0034, 32'h1C00_0004, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0));
    issue(mk_ex(1'b1, 1'b1, 5'd6, 32'h1000_0001, 4'b1000, 32'h1C00_0004, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0), 32'h8012_3456);
    cyc();
    exp_q.push_back(mk_wb(1'b1, 5'd8, 32'h0000_9ABC, 32'h1C00_0008, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0));
    issue(mk_ex(1'b1, 1'b1, 5'd8, 32'h1000_0002, 4'b1001, 32'h1C00_0008, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0), 32'h9ABC_1234);
    cyc();
    exp_q.push_back(mk_wb(1'b1, 5'd9, 32'h0000_1234, 32'h1C00_000C, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0));
    issue(mk_ex(1'b1, 1'b1, 5'd9, 32'h1000_0000, 4'b0001, 32'h1C00_000C, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0), 32'h9ABC_1234);
    cyc();
    exp_q.push_back(mk_wb(1'b1, 5'd10, 32'hFFFF_9ABC, 32'h1C00_0010, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0));
    issue(mk_ex(1'b1, 1'b1, 5'd10, 32'h1000_0006, 4'b0001, 32'h1C00_0010, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0), 32'h9ABC_1234);
    cyc();

    // LD.W held across a 3-cycle WB stall while EXE offers the next instruction
    wb_allowin = 1'b0;
    exp_q.push_back(mk_wb(1'b1, 5'd11, 32'h1111_1111, 32'h1C00_0014, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0));
    exp_q.push_back(mk_wb(1'b1, 5'd12, 32'h0000_0777, 32'h1C00_0018, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0));
    issue(mk_ex(1'b1, 1'b1, 5'd11, 32'h1000_0010, 4'b0010, 32'h1C00_0014, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0), 32'h1111_1111);
    exe_to_mem_valid = 1'b1;
    exe_to_mem_zip = mk_ex(1'b0, 1'b1, 5'd12, 32'h0000_0777, 4'b0000, 32'h1C00_0018, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid",   mem_to_wb_valid, 1'b1);
      chk("stall_allowin", mem_allowin, 1'b0);
      chk("stall_final",   mem_to_wb_zip[160:129], 32'h1111_1111);
      cyc();
      data_sram_rdata = 32'h2222_2222;
    end
    wb_allowin = 1'b1;
    @(negedge clk);
    chk("release_allowin", mem_allowin, 1'b1);
    cyc();
    exe_to_mem_valid = 1'b0;
    cyc();

    // faulting load: ALU result passes, exception state visible to EXEU and WB
    exp_q.push_back(mk_wb(1'b1, 5'd13, 32'h0000_1003, 32'h1C00_001C, 1'b0, 1'b1, 6'h09, 9'd0, 1'b0));
    issue(mk_ex(1'b1, 1'b1, 5'd13, 32'h0000_1003, 4'b0010, 32'h1C00_001C, 1'b0, 1'b1, 6'h09, 9'd0, 1'b0), 32'hDEAD_BEEF);
    @(negedge clk);
    chk("ex_mem_ex", mem_ex, 1'b1);
    cyc();
    @(negedge clk);
    chk("ex_gone", mem_ex, 1'b0);
    cyc();
    exp_q.push_back(mk_wb(1'b0, 5'd0, 32'h0000_0000, 32'h1C00_0020, 1'b0, 1'b0, 6'd0, 9'h003, 1'b1));
    issue(mk_ex(1'b0, 1'b0, 5'd0, 32'h0000_0000, 4'b0000, 32'h1C00_0020, 1'b0, 1'b0, 6'd0, 9'h003, 1'b1), 32'h0);
    @(negedge clk);
    chk("ertn_mem_ex", mem_ex, 1'b1);
    cyc();

    // flush with MEM empty: the incoming instruction is dropped
    flush = 1'b1;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_zip = mk_ex(1'b0, 1'b1, 5'd1, 32'h0, 4'b0000, 32'h1C00_0024, 1'b0, 1'b1, 6'h01, 9'd0, 1'b0);
    cyc();
    flush = 1'b0;
    exe_to_mem_valid = 1'b0;
    @(negedge clk);
    chk("flush_drop_valid", mem_to_wb_valid, 1'b0);
    chk("flush_drop_ex",    mem_ex, 1'b0);
    cyc();

    // flush while a stalled load has its data held and EXE offers another
    wb_allowin = 1'b0;
    issue(mk_ex(1'b1, 1'b1, 5'd2, 32'h1000_0020, 4'b0010, 32'h1C00_0028, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0), 32'hAAAA_5555);
    cyc();
    flush = 1'b1;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_zip = mk_ex(1'b0, 1'b1, 5'd3, 32'h0, 4'b0000, 32'h1C00_002C, 1'b0, 1'b1, 6'h02, 9'd0, 1'b0);
    data_sram_rdata = 32'h0;
    cyc();
    flush = 1'b0;
    exe_to_mem_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid",   mem_to_wb_valid, 1'b0);
    chk("flush_ex",      mem_ex, 1'b0);
    chk("flush_allowin", mem_allowin, 1'b1);
    cyc();
    // next load must see fresh SRAM data, not the flushed hold buffer
    exp_q.push_back(mk_wb(1'b1, 5'd14, 32'h0BAD_F00D, 32'h1C00_0030, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0));
    issue(mk_ex(1'b1, 1'b1, 5'd14, 32'h1000_0030, 4'b0010, 32'h1C00_0030, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0), 32'h0BAD_F00D);
    @(negedge clk);
    chk("post_flush_final", mem_to_wb_zip[160:129], 32'h0BAD_F00D);
    cyc();
    wb_allowin = 1'b1;
    cyc();

    // ST.W then ADD back to back, then a CSR read
    exp_q.push_back(mk_wb(1'b0, 5'd0, 32'h0000_2000, 32'h1C00_0034, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0));
    exp_q.push_back(mk_wb(1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0038, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0));
    exp_q.push_back(mk_wb(1'b1, 5'd7, 32'hCAFE_0000, 32'h1C00_003C, 1'b1, 1'b0, 6'd0, 9'd0, 1'b0));
    exe_to_mem_valid = 1'b1;
    exe_to_mem_zip = mk_ex(1'b0, 1'b0, 5'd0, 32'h0000_2000, 4'b0110, 32'h1C00_0034, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0);
    cyc();
    exe_to_mem_zip = mk_ex(1'b0, 1'b1, 5'd5, 32'h1234_5678, 4'b0000, 32'h1C00_0038, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0);
    data_sram_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("store_rfzip",   mem_rf_zip, {1'b0, 1'b0, 5'd0, 32'h0000_2000});
    chk("store_allowin", mem_allowin, 1'b1);
    cyc();
    exe_to_mem_zip = mk_ex(1'b0, 1'b1, 5'd7, 32'hCAFE_0000, 4'b0000, 32'h1C00_003C, 1'b1, 1'b0, 6'd0, 9'd0, 1'b0);
    @(negedge clk);
    chk("add_rfzip", mem_rf_zip, {1'b0, 1'b1, 5'd5, 32'h1234_5678});
    cyc();
    exe_to_mem_valid = 1'b0;
    @(negedge clk);
    chk("csr_rfzip", mem_rf_zip, {1'b1, 1'b1, 5'd7, 32'hCAFE_0000});
    cyc();
    @(negedge clk);
    chk("idle_rfvalid", mem_rf_zip[38:37], 2'b00);
    cyc();

    // asynchronous reset in the middle of a stall
    wb_allowin = 1'b0;
    issue(mk_ex(1'b1, 1'b1, 5'd15, 32'h1000_0040, 4'b0010, 32'h1C00_0040, 1'b0, 1'b1, 6'h03, 9'd0, 1'b0), 32'h3333_3333);
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid",   mem_to_wb_valid, 1'b0);
    chk("arst_allowin", mem_allowin, 1'b1);
    chk("arst_ex",      mem_ex, 1'b0);
    chk("arst_zip",     mem_to_wb_zip, 167'd0);
    cyc();
    reset = 1'b0;
    wb_allowin = 1'b1;
    cyc();

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
